// File: rtl/dense_layer_engine.sv
// dense_layer_engine: time-multiplexed dense layer with runtime-loaded weights/biases,
// LANES parallel MACs per pass, bias/ReLU/saturation, streamed results and argmax.
module dense_layer_engine #(
  parameter int NUM_IN  = 256,
  parameter int NUM_OUT = 10,
  parameter int LANES   = 2,
  parameter int DATA_W  = 8,
  parameter int FRAC_W  = 5,
  parameter int ACC_W   = 24
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               relu_en,
  input  logic                               wr_en,
  input  logic                               wr_bias,
  input  logic [$clog2(NUM_OUT*NUM_IN)-1:0]  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_W-1:0]                  in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_W-1:0]                  out_data,
  output logic [$clog2(NUM_OUT)-1:0]         out_idx,
  output logic                               done,
  output logic [$clog2(NUM_OUT)-1:0]         argmax,
  output logic                               busy
);
  localparam int NP = NUM_OUT / LANES;
  localparam int AW = $clog2(NUM_OUT * NUM_IN);
  localparam int OW = $clog2(NUM_OUT);
  localparam int IW = $clog2(NUM_IN);
  localparam int CW = $clog2(NUM_IN + 1);
  localparam int PW = NP > 1 ? $clog2(NP) : 1;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - 1;
  typedef enum logic [2:0] {IDLE, LOAD, MAC, BIAS, EMIT, DONE} state_t;
  state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [LW-1:0] lane_q, lane_d;
  logic relu_q, relu_d;
  logic signed [ACC_W-1:0] acc_q [LANES];
  logic signed [ACC_W-1:0] acc_d [LANES];
  logic signed [DATA_W-1:0] res_q [LANES];
  logic signed [DATA_W-1:0] res_d [LANES];
  logic signed [DATA_W-1:0] mx_q, mx_d;
  logic [OW-1:0] am_q, am_d;
  logic signed [ACC_W-1:0] s;
  logic [DATA_W-1:0] w_mem [NUM_OUT*NUM_IN];
  logic [DATA_W-1:0] b_mem [NUM_OUT];
  logic [DATA_W-1:0] x_mem [NUM_IN];
  logic signed [DATA_W-1:0] x_rd_q;
  logic signed [DATA_W-1:0] w_rd_q [LANES];
  logic signed [DATA_W-1:0] b_rd_q [LANES];
  logic [IW-1:0] rd_i;
  assign rd_i = cnt_q < CW'(NUM_IN) ? IW'(cnt_q) : '0;
  // Storage is never reset; reads are registered so the MAC phase runs one cycle behind the index.
  always_ff @(posedge clk) begin
    if (st_q == IDLE && wr_en && !wr_bias) w_mem[wr_addr] <= wr_data;
    if (st_q == IDLE && wr_en && wr_bias) b_mem[OW'(wr_addr)] <= wr_data;
    if (st_q == LOAD && in_valid) x_mem[IW'(cnt_q)] <= in_data;
    x_rd_q <= x_mem[rd_i];
    for (int l = 0; l < LANES; l++) begin
      w_rd_q[l] <= w_mem[AW'((int'(pass_q) * LANES + l) * NUM_IN + int'(rd_i))];
      b_rd_q[l] <= b_mem[OW'(int'(pass_q) * LANES + l)];
    end
  end
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    pass_d = pass_q;
    lane_d = lane_q;
    relu_d = relu_q;
    acc_d = acc_q;
    res_d = res_q;
    mx_d = mx_q;
    am_d = am_q;
    s = '0;
    case (st_q)
      IDLE: if (start) begin
        st_d = LOAD;
        cnt_d = '0;
        pass_d = '0;
        lane_d = '0;
        relu_d = relu_en;
        mx_d = DATA_W'(SMIN);
        am_d = '0;
      end
      LOAD: if (in_valid) begin
        cnt_d = cnt_q == CW'(NUM_IN - 1) ? '0 : cnt_q + 1'b1;
        st_d = cnt_q == CW'(NUM_IN - 1) ? MAC : LOAD;
      end
      MAC: begin
        for (int l = 0; l < LANES; l++)
          acc_d[l] = cnt_q == '0 ? '0 : acc_q[l] + ACC_W'(x_rd_q) * ACC_W'(w_rd_q[l]);
        cnt_d = cnt_q + 1'b1;
        st_d = cnt_q == CW'(NUM_IN) ? BIAS : MAC;
      end
      BIAS: begin
        // Lanes scanned in ascending order with strict > so ties keep the lower neuron.
        for (int l = 0; l < LANES; l++) begin
          s = (acc_q[l] + (ACC_W'(b_rd_q[l]) <<< FRAC_W)) >>> FRAC_W;
          s = (relu_q && s < 0) ? '0 : s;
          res_d[l] = DATA_W'(s > SMAX ? SMAX : (s < SMIN ? SMIN : s));
          if (res_d[l] > mx_d) begin
            mx_d = res_d[l];
            am_d = OW'(int'(pass_q) * LANES + l);
          end
        end
        lane_d = '0;
        st_d = EMIT;
      end
      EMIT: if (out_ready) begin
        if (lane_q == LW'(LANES - 1)) begin
          st_d = pass_q == PW'(NP - 1) ? DONE : MAC;
          pass_d = pass_q + 1'b1;
          cnt_d = '0;
        end else lane_d = lane_q + 1'b1;
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      pass_q <= '0;
      lane_q <= '0;
      relu_q <= 1'b0;
      mx_q <= '0;
      am_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
        res_q[l] <= '0;
      end
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      pass_q <= pass_d;
      lane_q <= lane_d;
      relu_q <= relu_d;
      mx_q <= mx_d;
      am_q <= am_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end
  assign in_ready = st_q == LOAD;
  assign out_valid = st_q == EMIT;
  assign done = st_q == DONE;
  assign busy = st_q != IDLE;
  assign out_data = res_q[lane_q];
  assign out_idx = OW'(int'(pass_q) * LANES + int'(lane_q));
  assign argmax = am_q;
endmodule

// File: tb/tb_dense_layer_engine.sv
// tb_dense_layer_engine: directed + randomized inferences checked against an arithmetic
// reference of the dense layer (sum of products, bias, floor shift, ReLU, clamp, argmax).
module tb_dense_layer_engine;
  localparam int NI = 4, NO = 4, LN = 2, DW = 8, FW = 5, AC = 24;
  logic clk = 0, rst = 1, start = 0, relu_en = 0, wr_en = 0, wr_bias = 0;
  logic [$clog2(NO*NI)-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0, in_data = '0, out_data;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, done, busy;
  logic [$clog2(NO)-1:0] out_idx, argmax;
  int vectors = 0, errs = 0;
  int W [NO][NI];
  int B [NO];
  int X [NI];
  int ey [NO];
  int eam;
  dense_layer_engine #(.NUM_IN(NI), .NUM_OUT(NO), .LANES(LN), .DATA_W(DW), .FRAC_W(FW), .ACC_W(AC)) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .wr_en(wr_en), .wr_bias(wr_bias),
    .wr_addr(wr_addr), .wr_data(wr_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .done(done), .argmax(argmax), .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model(input bit relu);
    int acc, v;
    for (int o = 0; o < NO; o++) begin
      acc = B[o] * (1 << FW);
      for (int i = 0; i < NI; i++) acc += X[i] * W[o][i];
      v = acc >>> FW;
      if (relu && v < 0) v = 0;
      ey[o] = v > 127 ? 127 : (v < -128 ? -128 : v);
    end
    eam = 0;
    for (int o = 1; o < NO; o++) if (ey[o] > ey[eam]) eam = o;
  endtask
  task automatic wr(input bit bias, input int addr, input int val);
    @(negedge clk);
    wr_en = 1; wr_bias = bias; wr_addr = 4'(addr); wr_data = 8'(val);
    @(negedge clk);
    wr_en = 0;
  endtask
  task automatic program_all();
    for (int o = 0; o < NO; o++) for (int i = 0; i < NI; i++) wr(0, o * NI + i, W[o][i]);
    for (int o = 0; o < NO; o++) wr(1, o, B[o]);
  endtask
  task automatic fill(input int w, input int b, input int x);
    for (int o = 0; o < NO; o++) begin
      B[o] = b;
      for (int i = 0; i < NI; i++) W[o][i] = w;
    end
    for (int i = 0; i < NI; i++) X[i] = x;
  endtask
  task automatic reset_checks();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_argmax", argmax, 0);
  endtask
  task automatic run(input bit relu, input bit rnd, input int stop_after, input bit wr_busy);
    int k;
    model(relu);
    @(negedge clk);
    start = 1; relu_en = relu;
    @(negedge clk);
    start = 0; relu_en = 0;
    for (int i = 0; i < NI; i++) begin
      in_valid = 1; in_data = 8'(X[i]);
      if (wr_busy) begin
        wr_en = 1; wr_bias = i[0]; wr_addr = 4'(i); wr_data = 8'(-5);
      end
      k = 0;
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      chk("in_ready", in_ready, 1);
      @(negedge clk);
      wr_en = 0;
    end
    in_valid = 0;
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    chk("latency", k, NI + 2);
    for (int o = 0; o < NO; o++) begin
      if (o == stop_after) begin
        @(negedge clk);
        @(negedge clk);
        chk("busy_before_abort", busy, 1);
        rst = 1;
        #1;
        reset_checks();
        @(negedge clk);
        rst = 0;
        repeat (NI + 6) begin
          @(negedge clk);
          chk("no_done_after_abort", done, 0);
        end
        return;
      end
      k = 0;
      while (!out_valid && k < 50) begin @(negedge clk); k++; end
      chk("out_valid", out_valid, 1);
      chk("out_data", $signed(out_data), ey[o]);
      chk("out_idx", out_idx, o);
      chk("done_early", done, 0);
      if (rnd) repeat ($urandom_range(3, 0)) begin
        out_ready = 0;
        @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", $signed(out_data), ey[o]);
        chk("stall_idx", out_idx, o);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
    end
    chk("done", done, 1);
    chk("argmax", argmax, eam);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("done_pulse", done, 0);
    chk("start_in_done_ignored", busy, 0);
    chk("argmax_held", argmax, eam);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 0;
    fill(32, 0, 16); program_all(); run(0, 0, -1, 0);
    B[2] = 32; wr(1, 2, 32); run(0, 0, -1, 0);
    for (int i = 0; i < NI; i++) begin W[1][i] = -32; wr(0, NI + i, -32); end
    run(0, 0, -1, 0);
    run(1, 0, -1, 0);
    fill(-128, 0, 127); program_all(); run(0, 0, -1, 0);
    fill(127, 0, 127); program_all(); run(0, 0, -1, 0);
    repeat (4) begin
      for (int o = 0; o < NO; o++) begin
        B[o] = int'($urandom_range(255, 0)) - 128;
        for (int i = 0; i < NI; i++) W[o][i] = int'($urandom_range(255, 0)) - 128;
      end
      for (int i = 0; i < NI; i++) X[i] = int'($urandom_range(255, 0)) - 128;
      program_all();
      run(1'($urandom_range(1, 0)), 1, -1, 0);
    end
    fill(32, 0, 16); program_all();
    run(0, 1, -1, 0);
    run(0, 0, 2, 0);
    run(0, 0, -1, 1);
    run(0, 0, -1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/dense_layer_engine.md
Name: dense_layer_engine

Overview:
Time-multiplexed, fully parametrised dense (fully-connected) layer. It buffers one input vector, computes NUM_OUT neurons in passes of LANES parallel MACs, and applies bias, optional ReLU and saturation. Results stream out over a valid/ready port, and the argmax is reported at the end of each inference. Weights and biases are loaded at runtime through a write port, so one instance serves as hidden or output layer and layers can be chained.

Parameters:
NUM_IN, 256, input vector length (>=2)
NUM_OUT, 10, neurons in layer; must be a multiple of LANES
LANES, 2, parallel MAC lanes per pass
DATA_W, 8, signed width of inputs, weights, biases, outputs
FRAC_W, 5, fractional bits of all DATA_W quantities
ACC_W, 24, signed accumulator width; must be >= 2*DATA_W+$clog2(NUM_IN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin inference; sampled only in IDLE
relu_en  in  1  1 = ReLU after bias; latched on start
wr_en  in  1  parameter write strobe; honoured only in IDLE
wr_bias  in  1  0 = weight, 1 = bias
wr_addr  in  $clog2(NUM_OUT*NUM_IN)  weight index o*NUM_IN+i; bias index o
wr_data  in  DATA_W  signed weight/bias value
in_valid  in  1  input sample valid
in_ready  out  1  engine accepts input sample
in_data  in  DATA_W  signed input sample, index order 0..NUM_IN-1
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  DATA_W  signed neuron activation
out_idx  out  $clog2(NUM_OUT)  neuron index of out_data
done  out  1  one-cycle pulse after last result accepted
argmax  out  $clog2(NUM_OUT)  index of largest result; valid with done, held until next start
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; in_ready, out_valid, done, busy = 0; out_data, out_idx, argmax = 0. Weight, bias and input storage are not cleared. Reset mid-inference aborts immediately; no done pulse is produced.
- IDLE: wr_en writes storage (1-cycle). start -> LOAD; a start asserted in the same cycle as wr_en still performs the write.
- LOAD: in_ready=1; each in_valid&in_ready handshake stores in_data at the next index. After the NUM_IN-th handshake -> MAC (pass 0), in_ready=0.
- MAC: one input index per cycle, i=0..NUM_IN-1; lane l of pass p computes neuron o=p*LANES+l. Storage read is synchronous (1-cycle), so the phase lasts NUM_IN+1 cycles. Accumulators are cleared at pass entry.
- BIAS (1 cycle): per lane, acc + (bias <<< FRAC_W), then >>> FRAC_W (arithmetic). Apply ReLU (negative -> 0) if latched relu_en. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Update argmax using strict greater-than, so ties keep the lower index.
- Latency: first out_valid is asserted exactly NUM_IN+2 cycles after the cycle of the last input handshake.
- EMIT: present lanes in ascending order; out_valid is held with stable out_data/out_idx until out_ready. After lane LANES-1 is accepted: next pass -> MAC; after the last pass -> DONE.
- DONE (1 cycle): done=1, argmax stable -> IDLE. start is ignored during DONE.
- Arithmetic: product is 2*DATA_W signed with 2*FRAC_W fractional bits. The accumulator wraps modulo 2^ACC_W; the parameter rule guarantees no overflow.
- Total cycles with out_ready tied high: NUM_IN (load) + (NUM_OUT/LANES)*(NUM_IN+2+LANES) + 1.

Test Plan:
NUM_IN=4, NUM_OUT=4, LANES=2, FRAC_W=5 for all scenarios.
1. All weights 32, biases 0, inputs 16, relu_en=0 -> out_data=64 for idx 0..3 in order; argmax=0 (tie); single done pulse.
2. Neuron 2 bias 32, others as (1) -> idx2 = 96, others 64; argmax=2.
3. Neuron 1 weights -32, inputs 16: relu_en=0 -> idx1 = -64; relu_en=1 -> idx1 = 0.
4. Weights -128, inputs 127 -> out_data=-128 (saturated). Weights 127, inputs 127 -> 127.
5. out_ready toggled 1/0 randomly -> same results and order; out_data/out_idx stable while stalled; first out_valid exactly 6 cycles after last input handshake.
6. rst asserted during MAC of pass 1 -> outputs 0 next edge, no done. A new start without reloading weights reproduces the scenario-1 results. wr_en while busy has no effect.
